// File: rtl/pingpong_buffer_pkg.sv
// ---------------------------------------------------------------------------
// pingpong_buffer_pkg
// Shared types and helpers for the ping/pong buffer memory.
//   buf_state_t  : ownership state of one buffer set (FREE = owned by the
//                  fill side, FULL = owned by the drain side)
//   set_state_t  : ownership state of both sets, indexed by set number
//   bank_count() : number of banks per set for a given log2 bank count
// ---------------------------------------------------------------------------
package pingpong_buffer_pkg;

    localparam int NUM_SETS = 2;

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } buf_state_t;

    typedef buf_state_t set_state_t [NUM_SETS];

    function automatic int bank_count(input int depth);
        return 1 << depth;
    endfunction

endpackage

// File: rtl/buffer_bank.sv
// ---------------------------------------------------------------------------
// buffer_bank
// One W-bit x 2^A single-port RAM with write enable and a registered read
// port. The read register only changes on a read request, so it holds the
// last word fetched until the next read; it is the only resettable state.
// Ports:
//   CLK      : clock, rising edge
//   RSTn     : asynchronous active-low reset (clears the read register only)
//   we_i     : write enable, writes wdata_i at addr_i
//   re_i     : read enable, captures mem[addr_i] into rdata_o
//   addr_i   : shared word address
//   wdata_i  : write data
//   rdata_o  : registered read data
// ---------------------------------------------------------------------------
module buffer_bank #(
    parameter int A = 7,
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         we_i,
    input  logic         re_i,
    input  logic [A-1:0] addr_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o
);

    logic [W-1:0] mem_q [1 << A];
    logic [W-1:0] rdata_q;

    // Storage array: plain RAM with no reset so it maps onto memory macros.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: holds its value between reads and clears on reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_buffer_memory.sv
// ---------------------------------------------------------------------------
// pingpong_buffer_memory
// Double-buffered bank memory between the DMA/input loader (fill side) and
// the PE array feeder (drain side). Two identical sets of D banks; the fill
// side writes the set selected by fill_sel while the drain side reads the set
// selected by drain_sel. A set passes to the drain side on an accepted write
// with wr_last and back to the fill side on an accepted read with rd_last.
// Ports:
//   CLK, RSTn          : clock and asynchronous active-low reset
//   flush              : synchronous clear of ownership state and error flags
//   wr_en/wr_bank_mask : fill write request and per-bank enable
//   wr_addr/wr_data    : fill address and data (bank i at [W*i +: W])
//   wr_last            : marks the fill set complete
//   fill_ready         : fill set is FREE
//   rd_en/rd_addr      : drain read request and address
//   rd_last            : releases the drain set
//   drain_ready        : drain set is FULL
//   rd_data/rd_valid   : registered read data, valid one cycle after a read
//   occupancy          : number of FULL sets
//   fill_sel/drain_sel : set index targeted by each side
//   err_wr/err_rd      : sticky flags for requests made while not ready
// ---------------------------------------------------------------------------
module pingpong_buffer_memory
    import pingpong_buffer_pkg::*;
#(
    parameter  int DEPTH = 3,
    parameter  int A     = 7,
    parameter  int W     = 3,
    localparam int D     = bank_count(DEPTH)
) (
    input  logic           CLK,
    input  logic           RSTn,
    input  logic           flush,
    input  logic           wr_en,
    input  logic [D-1:0]   wr_bank_mask,
    input  logic [A-1:0]   wr_addr,
    input  logic [W*D-1:0] wr_data,
    input  logic           wr_last,
    output logic           fill_ready,
    input  logic           rd_en,
    input  logic [A-1:0]   rd_addr,
    input  logic           rd_last,
    output logic           drain_ready,
    output logic [W*D-1:0] rd_data,
    output logic           rd_valid,
    output logic [1:0]     occupancy,
    output logic           fill_sel,
    output logic           drain_sel,
    output logic           err_wr,
    output logic           err_rd
);

    set_state_t state_q, state_d;
    logic       fp_q, fp_d;
    logic       dp_q, dp_d;
    logic       rd_valid_q, rd_valid_d;
    logic       rd_set_q, rd_set_d;
    logic       err_wr_q, err_wr_d;
    logic       err_rd_q, err_rd_d;
    logic       wr_accept;
    logic       rd_accept;

    logic [W-1:0] bank_rdata [NUM_SETS][D];

    // Handshake status is derived straight from the ownership registers.
    assign fill_ready  = (state_q[fp_q] == FREE);
    assign drain_ready = (state_q[dp_q] == FULL);
    assign occupancy   = 2'(state_q[0] == FULL) + 2'(state_q[1] == FULL);

    // flush masks both sides so nothing is written or read in that cycle.
    assign wr_accept = wr_en & fill_ready & ~flush;
    assign rd_accept = rd_en & drain_ready & ~flush;

    // Ownership, pointer and error next-state. An accepted write and an
    // accepted read always hit different sets (one FREE, one FULL), so both
    // state updates can be applied in the same cycle without clashing.
    always_comb begin
        state_d    = state_q;
        fp_d       = fp_q;
        dp_d       = dp_q;
        rd_valid_d = 1'b0;
        rd_set_d   = rd_set_q;
        err_wr_d   = err_wr_q;
        err_rd_d   = err_rd_q;
        if (flush) begin
            state_d[0] = FREE;
            state_d[1] = FREE;
            fp_d       = 1'b0;
            dp_d       = 1'b0;
            err_wr_d   = 1'b0;
            err_rd_d   = 1'b0;
        end else begin
            if (wr_en && !fill_ready) begin
                err_wr_d = 1'b1;
            end
            if (rd_en && !drain_ready) begin
                err_rd_d = 1'b1;
            end
            if (wr_accept && wr_last) begin
                state_d[fp_q] = FULL;
                fp_d          = ~fp_q;
            end
            if (rd_accept) begin
                rd_valid_d = 1'b1;
                rd_set_d   = dp_q;
            end
            if (rd_accept && rd_last) begin
                state_d[dp_q] = FREE;
                dp_d          = ~dp_q;
            end
        end
    end

    // Control registers; reset returns both sets to the fill side at once.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q[0] <= FREE;
            state_q[1] <= FREE;
            fp_q       <= 1'b0;
            dp_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_set_q   <= 1'b0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fp_q       <= fp_d;
            dp_q       <= dp_d;
            rd_valid_q <= rd_valid_d;
            rd_set_q   <= rd_set_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
        end
    end

    // Bank arrays. Each set shares one address bus; it carries the write
    // address only when that set is actually being written, otherwise the
    // read address.
    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        localparam logic SET_IDX = 1'(s);
        logic         set_wr;
        logic         set_rd;
        logic [A-1:0] set_addr;

        assign set_wr   = wr_accept & (fp_q == SET_IDX);
        assign set_rd   = rd_accept & (dp_q == SET_IDX);
        assign set_addr = set_wr ? wr_addr : rd_addr;

        for (genvar b = 0; b < D; b++) begin : g_bank
            buffer_bank #(
                .A (A),
                .W (W)
            ) u_bank (
                .CLK     (CLK),
                .RSTn    (RSTn),
                .we_i    (set_wr & wr_bank_mask[b]),
                .re_i    (set_rd),
                .addr_i  (set_addr),
                .wdata_i (wr_data[W*b +: W]),
                .rdata_o (bank_rdata[s][b])
            );
        end
    end

    // Output mux: the bank read registers hold between reads, so selecting
    // the set of the most recent accepted read gives held rd_data for free.
    always_comb begin
        rd_data = '0;
        for (int b = 0; b < D; b++) begin
            rd_data[W*b +: W] = bank_rdata[rd_set_q][b];
        end
    end

    assign rd_valid  = rd_valid_q;
    assign fill_sel  = fp_q;
    assign drain_sel = dp_q;
    assign err_wr    = err_wr_q;
    assign err_rd    = err_rd_q;

endmodule

// File: doc/pingpong_buffer_memory.md
Name: pingpong_buffer_memory

Overview:
Double-buffered (ping/pong) successor to the single-set bank buffer memory. It holds two identical buffer sets, each made of D = 1<<DEPTH banks of W-bit words with 2^A entries. A fill side writes one set with per-bank write masking while a drain side reads the other set, all banks in parallel. Ownership of each set passes between the sides via a last-beat handshake. The block sits between the DMA/input loader and the PE array feeder.

Parameters:
DEPTH, 3, log2 of bank count; D = 1<<DEPTH banks per set
A, 7, address width; each bank holds 2^A words
W, 3, bits per bank word; data buses are W*D bits wide

Ports:
CLK  in  1  clock, all state updates on rising edge
RSTn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of buffer ownership; highest priority
wr_en  in  1  fill-side write request
wr_bank_mask  in  D  per-bank write enable; bit i gates wr_data[W*i +: W]
wr_addr  in  A  fill-side word address
wr_data  in  W*D  fill-side data, bank i in bits [W*i +: W]
wr_last  in  1  with an accepted write: the fill set is complete
fill_ready  out  1  fill set is FREE; writes are accepted
rd_en  in  1  drain-side read request
rd_addr  in  A  drain-side word address
rd_last  in  1  with an accepted read: the drain set is released
drain_ready  out  1  drain set is FULL; reads are accepted
rd_data  out  W*D  registered read data, all banks concatenated
rd_valid  out  1  rd_data holds the result of the read accepted last cycle
occupancy  out  2  number of FULL sets, 0..2
fill_sel  out  1  index of the set the fill side currently targets
drain_sel  out  1  index of the set the drain side currently targets
err_wr  out  1  sticky: a write was attempted while fill_ready=0
err_rd  out  1  sticky: a read was attempted while drain_ready=0

Behaviour:
- Per-set state: FREE or FULL. Pointers fp (fill_sel) and dp (drain_sel).
- Reset (RSTn=0, async): both sets FREE; fp=0; dp=0; rd_data=0; rd_valid=0; err_wr=0; err_rd=0. Outputs then read fill_ready=1, drain_ready=0, occupancy=0. Memory contents are not reset.
- fill_ready = (state[fp]==FREE). drain_ready = (state[dp]==FULL). Both are combinational from registers. occupancy is the count of FULL sets.
- Write accept = wr_en & fill_ready.
  - On accept, bank i of set fp at wr_addr is written where wr_bank_mask[i]=1.
  - If wr_last is also set: state[fp] becomes FULL and fp toggles at that edge.
  - wr_en & !fill_ready: no write, no state change, err_wr is set.
- Read accept = rd_en & drain_ready.
  - On accept, all banks of set dp at rd_addr are read. rd_data updates at the next edge and rd_valid=1 for exactly that cycle. Latency is 1 cycle.
  - If rd_last is also set: state[dp] becomes FREE and dp toggles. Data for that read is still returned.
  - rd_en & !drain_ready: rd_valid=0 next cycle, rd_data holds its value, err_rd is set.
- With no accepted read, rd_valid=0 next cycle and rd_data holds.
- Simultaneous accepted write and read always target different sets, because one must be FREE and the other FULL. Both proceed, including simultaneous wr_last and rd_last, which can make occupancy unchanged.
- Two-FULL case: fill_ready=0 until a rd_last frees a set. Zero-FULL case: drain_ready=0.
- flush=1 (sync): both sets FREE, fp=dp=0, rd_valid=0. The write and read in that cycle are ignored. err_* are cleared. Memory contents are kept.
- Reset asserted mid-transfer: pending rd_valid is dropped and both sets become FREE immediately.
- Address wrap-around is not applicable; addresses are used directly, with no internal counters.

Decomposition:
- Package pingpong_buffer_pkg:
  - buf_state_t enum {FREE, FULL}
  - function for bank count from DEPTH
  - typedef for the per-set state array
- Sub-module buffer_bank: one W x 2^A single-port RAM with write enable and registered read. It is instantiated 2*D times.
- Top-level logic owns the FSM, pointers, output mux between sets, and error flags.

Test Plan:
- Reset, write addr 5 data 0x123 mask all-ones with wr_last, then read addr 5 with rd_last. Expected: drain_ready=1 after the write edge; rd_data=0x123 with rd_valid one cycle after the read; occupancy goes 0->1->0; fill_sel and drain_sel both 1 at the end.
- Fill both sets, set 0 with 0x0AA at addr 0 and set 1 with 0x055 at addr 0, both with wr_last. Expected: occupancy=2, fill_ready=0. A further write sets err_wr, and both sets keep their contents on readback.
- Masked write: mask=8'b0000_0001, data 0xFFFFFF onto a location holding 0. Expected: readback is 0x000007.
- Simultaneous wr_last to set 1 and rd_last from set 0 in the same cycle. Expected: occupancy stays 1, fill_sel=0, drain_sel=1, data intact.
- Read while empty. Expected: rd_valid=0, err_rd=1, and err_rd stays set until flush.
- flush with one set FULL and a read in flight. Expected: next cycle occupancy=0, rd_valid=0, err_*=0, fill_ready=1.
